// File: rtl/ctrl_hazard_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_hazard_pipe
// Description : Hazard and forwarding control for a 5-stage pipeline. It
//               carries destination/write/load information through EX, MEM
//               and WB. It raises load-use stalls and control-flow flushes,
//               and it produces the EX-stage operand forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_hazard_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_func,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_RegWrite,
    input  logic [1:0]       id_RegDest,
    input  logic [1:0]       id_jump,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush_if_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             wb_en,
    output logic [4:0]       wb_dst,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [5:0] c_OP_RTYPE = 6'h03;
    localparam logic [5:0] c_OP_LW    = 6'h12;
    localparam logic [5:0] c_OP_LBU   = 6'h22;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h07;
    localparam logic [5:0] c_OP_LUI   = 6'h0F;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_SB    = 6'h28;
    localparam logic [5:0] c_OP_SW    = 6'h2B;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_LWN   = 6'h21;
    localparam logic [1:0] c_FWD_RF   = 2'b00;
    localparam logic [1:0] c_FWD_MEM  = 2'b01;
    localparam logic [1:0] c_FWD_WB   = 2'b10;

    // Stage registers. The load flag is only consulted while the producer
    // sits in EX (load-use detection), so it is not carried further.
    logic             r_ex_valid, r_ex_wr, r_ex_load;
    logic [4:0]       r_ex_dst, r_ex_rs, r_ex_rt;
    logic             r_mem_valid, r_mem_wr;
    logic [4:0]       r_mem_dst;
    logic             r_wb_valid, r_wb_wr;
    logic [4:0]       r_wb_dst;
    logic [CNT_W-1:0] r_stall_count;

    logic [4:0] w_id_dst;
    logic       w_id_wr;
    logic       w_id_load;
    logic       w_uses_rs;
    logic       w_uses_rt;
    logic       w_load_use;
    logic       w_mem_fwd_ok;
    logic       w_wb_fwd_ok;

    // Decode-side destination, load and source-usage classification
    always_comb begin
        case (id_RegDest)
            2'b00:   w_id_dst = id_rt;
            2'b01:   w_id_dst = id_rd;
            2'b10:   w_id_dst = 5'd31;
            default: w_id_dst = 5'd0;
        endcase
        w_id_wr   = id_valid & id_RegWrite & (w_id_dst != 5'd0);
        w_id_load = (id_opcode == c_OP_LW) | (id_opcode == c_OP_LBU) |
                    ((id_opcode == c_OP_RTYPE) & (id_func == c_FN_LWN));
        w_uses_rs = !((id_opcode == c_OP_J) | (id_opcode == c_OP_JAL) |
                      (id_opcode == c_OP_LUI));
        w_uses_rt = (id_opcode == c_OP_BEQ) | (id_opcode == c_OP_BNE) |
                    (id_opcode == c_OP_SB)  | (id_opcode == c_OP_SW)  |
                    ((id_opcode == c_OP_RTYPE) & (id_func != c_FN_JR) &
                     (id_func != c_FN_LWN));
    end

    // A load in EX whose destination feeds the instruction in ID.
    // A load to $0 has wr=0, so $0 is never a stall source.
    assign w_load_use = r_ex_valid & r_ex_load & r_ex_wr & id_valid &
                        ((w_uses_rs & (id_rs == r_ex_dst)) |
                         (w_uses_rt & (id_rt == r_ex_dst)));

    // Hazard priority: taken branch beats load-use, which beats a jump.
    // A jump held by a stall flushes on the cycle the stall clears.
    always_comb begin
        stall       = 1'b0;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (w_load_use) begin
            stall     = 1'b1;
            bubble_ex = 1'b1;
        end else if (id_valid && (id_jump != 2'b00)) begin
            flush_if_id = 1'b1;
        end
    end

    assign w_mem_fwd_ok = r_mem_valid & r_mem_wr;
    assign w_wb_fwd_ok  = r_wb_valid & r_wb_wr;

    // EX operand forwarding; the younger MEM result wins over WB
    always_comb begin
        fwd_a = c_FWD_RF;
        fwd_b = c_FWD_RF;
        if ((r_ex_rs != 5'd0) && w_mem_fwd_ok && (r_mem_dst == r_ex_rs)) begin
            fwd_a = c_FWD_MEM;
        end else if ((r_ex_rs != 5'd0) && w_wb_fwd_ok && (r_wb_dst == r_ex_rs)) begin
            fwd_a = c_FWD_WB;
        end
        if ((r_ex_rt != 5'd0) && w_mem_fwd_ok && (r_mem_dst == r_ex_rt)) begin
            fwd_b = c_FWD_MEM;
        end else if ((r_ex_rt != 5'd0) && w_wb_fwd_ok && (r_wb_dst == r_ex_rt)) begin
            fwd_b = c_FWD_WB;
        end
    end

    // Stage registers advance every cycle; ID->EX takes a bubble on demand
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_wr     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_ex_dst    <= 5'd0;
            r_ex_rs     <= 5'd0;
            r_ex_rt     <= 5'd0;
            r_mem_valid <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_dst   <= 5'd0;
            r_wb_valid  <= 1'b0;
            r_wb_wr     <= 1'b0;
            r_wb_dst    <= 5'd0;
        end else begin
            if (bubble_ex) begin
                r_ex_valid <= 1'b0;
                r_ex_wr    <= 1'b0;
                r_ex_load  <= 1'b0;
                r_ex_dst   <= 5'd0;
                r_ex_rs    <= 5'd0;
                r_ex_rt    <= 5'd0;
            end else begin
                r_ex_valid <= id_valid;
                r_ex_wr    <= w_id_wr;
                r_ex_load  <= id_valid & w_id_load;
                r_ex_dst   <= w_id_dst;
                r_ex_rs    <= id_rs;
                r_ex_rt    <= id_rt;
            end
            r_mem_valid <= r_ex_valid;
            r_mem_wr    <= r_ex_wr;
            r_mem_dst   <= r_ex_dst;
            r_wb_valid  <= r_mem_valid;
            r_wb_wr     <= r_mem_wr;
            r_wb_dst    <= r_mem_dst;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (stall && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign wb_en       = r_wb_valid & r_wb_wr;
    assign wb_dst      = r_wb_dst;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_hazard_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_hazard_pipe
// Description : Self-checking bench for ctrl_hazard_pipe. The bench plays the
//               front end (holds ID on stall, inserts killed slots after
//               flushes) and keeps a queue of expected register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_hazard_pipe;

    localparam int CW = 8;

    typedef struct packed {
        logic       v;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] rdst;
        logic [1:0] jmp;
    } instr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid, id_RegWrite, ex_branch_taken;
    logic [5:0]    id_opcode, id_func;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic [1:0]    id_RegDest, id_jump;
    logic          stall, flush_if_id, bubble_ex, wb_en;
    logic [1:0]    fwd_a, fwd_b;
    logic [4:0]    wb_dst;
    logic [CW-1:0] stall_count;

    int            errors = 0;
    int            checks = 0;
    logic [4:0]    exp_wb[$];
    logic [4:0]    exp_d;
    logic [CW-1:0] exp_sc;

    ctrl_hazard_pipe #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_RegWrite(id_RegWrite), .id_RegDest(id_RegDest), .id_jump(id_jump),
        .ex_branch_taken(ex_branch_taken), .stall(stall),
        .flush_if_id(flush_if_id), .bubble_ex(bubble_ex), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .wb_en(wb_en), .wb_dst(wb_dst), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1);
    end

    // Scoreboard: every register-file write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && wb_en) begin
            checks++;
            if (exp_wb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: wb_dst=%0d, required no write", wb_dst);
            end else begin
                exp_d = exp_wb.pop_front();
                if (wb_dst !== exp_d) begin
                    errors++;
                    $display("FAIL wb_dst: got %0d, required %0d", wb_dst, exp_d);
                end
            end
        end
    end

    function automatic instr_t f_nop();
        return '0;
    endfunction
    function automatic instr_t f_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return '{v:1'b1, op:6'h03, fn:6'h20, rs:rs, rt:rt, rd:rd, rw:1'b1, rdst:2'b01, jmp:2'b00};
    endfunction
    function automatic instr_t f_lw(input logic [4:0] rt, input logic [4:0] rs);
        return '{v:1'b1, op:6'h12, fn:6'h00, rs:rs, rt:rt, rd:5'd0, rw:1'b1, rdst:2'b00, jmp:2'b00};
    endfunction
    function automatic instr_t f_addi(input logic [4:0] rt, input logic [4:0] rs);
        return '{v:1'b1, op:6'h08, fn:6'h05, rs:rs, rt:rt, rd:5'd0, rw:1'b1, rdst:2'b00, jmp:2'b00};
    endfunction
    function automatic instr_t f_beq(input logic [4:0] rs, input logic [4:0] rt);
        return '{v:1'b1, op:6'h04, fn:6'h00, rs:rs, rt:rt, rd:5'd0, rw:1'b0, rdst:2'b00, jmp:2'b00};
    endfunction
    function automatic instr_t f_jal();
        return '{v:1'b1, op:6'h07, fn:6'h00, rs:5'd0, rt:5'd0, rd:5'd0, rw:1'b1, rdst:2'b10, jmp:2'b01};
    endfunction
    function automatic instr_t f_jr(input logic [4:0] rs);
        return '{v:1'b1, op:6'h03, fn:6'h08, rs:rs, rt:5'd0, rd:5'd0, rw:1'b0, rdst:2'b00, jmp:2'b10};
    endfunction

    task automatic set_id(input instr_t i);
        id_valid    = i.v;
        id_opcode   = i.op;
        id_func     = i.fn;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_rd       = i.rd;
        id_RegWrite = i.rw;
        id_RegDest  = i.rdst;
        id_jump     = i.jmp;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        set_id(f_nop());
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(f_nop());
        tick();
        tick();
        checks++;
        if ({stall, flush_if_id, bubble_ex, fwd_a, fwd_b} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hazard: got %b, required 0000000", {stall, flush_if_id, bubble_ex, fwd_a, fwd_b});
        end
        checks++;
        if ({wb_en, wb_dst, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_wb_cnt: wb_en=%b wb_dst=%0d cnt=%0d, required 0/0/0", wb_en, wb_dst, stall_count);
        end
        rst = 1'b0;
        exp_sc = '0;
    endtask

    task automatic test_fwd_alu();
        set_id(f_add(5'd3, 5'd1, 5'd2)); exp_wb.push_back(5'd3); tick();
        set_id(f_add(5'd4, 5'd3, 5'd3));
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL alu_no_stall: got %b, required 0", stall); end
        exp_wb.push_back(5'd4); tick();
        set_id(f_nop());
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0101) begin
            errors++; $display("FAIL alu_fwd_mem: got a=%b b=%b, required 01/01", fwd_a, fwd_b);
        end
        drain();
        // WB forwarding with a one-slot gap
        set_id(f_add(5'd3, 5'd1, 5'd2)); exp_wb.push_back(5'd3); tick();
        set_id(f_nop()); tick();
        set_id(f_add(5'd4, 5'd3, 5'd1)); exp_wb.push_back(5'd4); tick();
        set_id(f_nop());
        checks++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin
            errors++; $display("FAIL alu_fwd_wb: got a=%b b=%b, required 10/00", fwd_a, fwd_b);
        end
        drain();
        // Two writers of $7 in flight: the younger (MEM) one wins
        set_id(f_add(5'd7, 5'd1, 5'd1)); exp_wb.push_back(5'd7); tick();
        set_id(f_add(5'd7, 5'd2, 5'd2)); exp_wb.push_back(5'd7); tick();
        set_id(f_add(5'd8, 5'd7, 5'd7)); exp_wb.push_back(5'd8); tick();
        set_id(f_nop());
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0101) begin
            errors++; $display("FAIL fwd_mem_priority: got a=%b b=%b, required 01/01", fwd_a, fwd_b);
        end
        drain();
        checks++;
        if (exp_wb.size() != 0) begin errors++; $display("FAIL alu_wb_missing: got %0d pending, required 0", exp_wb.size()); end
    endtask

    task automatic test_load_use();
        set_id(f_lw(5'd5, 5'd1)); exp_wb.push_back(5'd5); tick();
        set_id(f_add(5'd6, 5'd5, 5'd0));
        checks++;
        if ({stall, flush_if_id, bubble_ex} !== 3'b101) begin
            errors++; $display("FAIL lu_stall: got s/f/b=%b, required 101", {stall, flush_if_id, bubble_ex});
        end
        exp_sc = exp_sc + 1'b1;
        tick();
        // dependent instruction held in ID for one more cycle
        checks++;
        if ({stall, bubble_ex, stall_count} !== {2'b00, exp_sc}) begin
            errors++; $display("FAIL lu_release: got s=%b b=%b cnt=%0d, required 0/0/%0d", stall, bubble_ex, stall_count, exp_sc);
        end
        exp_wb.push_back(5'd6); tick();
        set_id(f_nop());
        // dependent in EX, load has moved on to WB by now
        checks++;
        if ({fwd_a, fwd_b} !== 4'b1000) begin
            errors++; $display("FAIL lu_fwd: got a=%b b=%b, required 10/00", fwd_a, fwd_b);
        end
        checks++;
        if ({wb_en, wb_dst} !== {1'b1, 5'd5}) begin
            errors++; $display("FAIL lu_wb: got en=%b dst=%0d, required 1/5", wb_en, wb_dst);
        end
        drain();
        checks++;
        if (exp_wb.size() != 0) begin errors++; $display("FAIL lu_wb_missing: got %0d pending, required 0", exp_wb.size()); end
    endtask

    task automatic test_branch();
        // Taken branch while ID holds a load-dependent instruction
        set_id(f_lw(5'd7, 5'd1)); exp_wb.push_back(5'd7); tick();
        ex_branch_taken = 1'b1;
        set_id(f_add(5'd8, 5'd7, 5'd7));
        checks++;
        if ({stall, flush_if_id, bubble_ex} !== 3'b011) begin
            errors++; $display("FAIL br_over_lu: got s/f/b=%b, required 011", {stall, flush_if_id, bubble_ex});
        end
        tick();
        ex_branch_taken = 1'b0;
        set_id(f_nop());
        checks++;
        if (stall_count !== exp_sc) begin
            errors++; $display("FAIL br_cnt: got %0d, required %0d", stall_count, exp_sc);
        end
        drain();
        // Plain taken branch
        set_id(f_beq(5'd1, 5'd2)); tick();
        ex_branch_taken = 1'b1;
        set_id(f_add(5'd9, 5'd1, 5'd1));
        checks++;
        if ({stall, flush_if_id, bubble_ex} !== 3'b011) begin
            errors++; $display("FAIL br_plain: got s/f/b=%b, required 011", {stall, flush_if_id, bubble_ex});
        end
        tick();
        ex_branch_taken = 1'b0;
        drain();
        checks++;
        if (exp_wb.size() != 0) begin errors++; $display("FAIL br_wb_missing: got %0d pending, required 0", exp_wb.size()); end
    endtask

    task automatic test_jump();
        set_id(f_jal());
        checks++;
        if ({stall, flush_if_id, bubble_ex} !== 3'b010) begin
            errors++; $display("FAIL jal_flush: got s/f/b=%b, required 010", {stall, flush_if_id, bubble_ex});
        end
        exp_wb.push_back(5'd31); tick();
        set_id(f_nop());
        checks++;
        if (flush_if_id !== 1'b0) begin errors++; $display("FAIL jal_flush_once: got %b, required 0", flush_if_id); end
        tick();
        set_id(f_jr(5'd31));
        checks++;
        if ({stall, flush_if_id, bubble_ex} !== 3'b010) begin
            errors++; $display("FAIL jr_flush: got s/f/b=%b, required 010", {stall, flush_if_id, bubble_ex});
        end
        tick();
        set_id(f_nop());
        checks++;
        if ({fwd_a, wb_en, wb_dst} !== {2'b10, 1'b1, 5'd31}) begin
            errors++; $display("FAIL jr_fwd_wb: got a=%b en=%b dst=%0d, required 10/1/31", fwd_a, wb_en, wb_dst);
        end
        drain();
        // Jump behind a load-use stall: flush waits for the stall to clear
        set_id(f_lw(5'd9, 5'd1)); exp_wb.push_back(5'd9); tick();
        set_id(f_jr(5'd9));
        checks++;
        if ({stall, flush_if_id, bubble_ex} !== 3'b101) begin
            errors++; $display("FAIL jmp_defer_stall: got s/f/b=%b, required 101", {stall, flush_if_id, bubble_ex});
        end
        exp_sc = exp_sc + 1'b1;
        tick();
        checks++;
        if ({stall, flush_if_id, bubble_ex} !== 3'b010) begin
            errors++; $display("FAIL jmp_defer_flush: got s/f/b=%b, required 010", {stall, flush_if_id, bubble_ex});
        end
        tick();
        drain();
        checks++;
        if (exp_wb.size() != 0) begin errors++; $display("FAIL jmp_wb_missing: got %0d pending, required 0", exp_wb.size()); end
    endtask

    task automatic test_zero_reg();
        set_id(f_addi(5'd0, 5'd1)); tick();
        set_id(f_add(5'd2, 5'd0, 5'd0)); exp_wb.push_back(5'd2); tick();
        set_id(f_nop());
        checks++;
        if ({fwd_a, fwd_b} !== 4'b0000) begin
            errors++; $display("FAIL zero_fwd: got a=%b b=%b, required 00/00", fwd_a, fwd_b);
        end
        tick();
        checks++;
        if (wb_en !== 1'b0) begin errors++; $display("FAIL zero_wb: got %b, required 0", wb_en); end
        drain();
        // A load to $0 never causes a stall
        set_id(f_lw(5'd0, 5'd1)); tick();
        set_id(f_add(5'd3, 5'd0, 5'd0));
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL zero_load_stall: got %b, required 0", stall); end
        exp_wb.push_back(5'd3); tick();
        drain();
        checks++;
        if (exp_wb.size() != 0) begin errors++; $display("FAIL zero_wb_missing: got %0d pending, required 0", exp_wb.size()); end
    endtask

    task automatic test_saturate_and_reset();
        for (int n = 0; n < (1 << CW) + 3; n++) begin
            set_id(f_lw(5'd10, 5'd1)); exp_wb.push_back(5'd10); tick();
            set_id(f_add(5'd11, 5'd10, 5'd10));
            checks++;
            if (stall !== 1'b1) begin errors++; $display("FAIL sat_stall[%0d]: got %b, required 1", n, stall); end
            exp_sc = (exp_sc == {CW{1'b1}}) ? exp_sc : exp_sc + 1'b1;
            tick();
            checks++;
            if (stall_count !== exp_sc) begin
                errors++; $display("FAIL sat_cnt[%0d]: got %0d, required %0d", n, stall_count, exp_sc);
            end
            exp_wb.push_back(5'd11); tick();
        end
        checks++;
        if (stall_count !== {CW{1'b1}}) begin
            errors++; $display("FAIL sat_final: got %0d, required %0d", stall_count, (1 << CW) - 1);
        end
        // Reset while a load-use stall is active
        set_id(f_lw(5'd10, 5'd1)); tick();
        set_id(f_add(5'd11, 5'd10, 5'd10));
        rst = 1'b1;
        exp_wb.delete();
        tick();
        checks++;
        if ({stall, flush_if_id, bubble_ex, fwd_a, fwd_b} !== 7'b0) begin
            errors++; $display("FAIL midrst_hazard: got %b, required 0000000", {stall, flush_if_id, bubble_ex, fwd_a, fwd_b});
        end
        checks++;
        if ({wb_en, wb_dst, stall_count} !== '0) begin
            errors++; $display("FAIL midrst_wb_cnt: got en=%b dst=%0d cnt=%0d, required 0/0/0", wb_en, wb_dst, stall_count);
        end
        rst = 1'b0;
        exp_sc = '0;
        drain();
    endtask

    initial begin
        ex_branch_taken = 1'b0;
        set_id(f_nop());
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_branch();
        test_jump();
        test_zero_reg();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
